// File: rtl/ram_banked_pkg.sv
// Shared types and width helpers for the banked RAM controller.
package ram_banked_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } ram_state_t;

    function automatic int lanes_f(input int data_width, input int lane_width);
        return data_width / lane_width;
    endfunction

    function automatic int row_bits_f(input int addr_width, input int bank_bits);
        return addr_width - bank_bits;
    endfunction

endpackage

// File: rtl/ram_bank.sv
// One RAM bank: 2^ROW_BITS words, per-lane write enables, registered read port.
module ram_bank #(
    parameter int ROW_BITS   = 12,
    parameter int DATA_WIDTH = 16,
    parameter int LANE_WIDTH = 8,
    parameter int LANES      = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we_i,
    input  logic [LANES-1:0]      lane_we_i,
    input  logic                  re_i,
    input  logic [ROW_BITS-1:0]   row_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [LANES-1:0][LANE_WIDTH-1:0] mem_q [2**ROW_BITS];
    logic [DATA_WIDTH-1:0]            rdata_q;

    // The array has no reset so it maps onto plain RAM macros.
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int l = 0; l < LANES; l++) begin
                if (lane_we_i[l]) begin
                    mem_q[row_i][l] <= wdata_i[l*LANE_WIDTH +: LANE_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[row_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ram_banked_ctrl.sv
// Banked single-port RAM with valid/ready request and response channels and
// a hardware fill of every word after reset.
module ram_banked_ctrl
    import ram_banked_pkg::*;
#(
    parameter int                      ADDR_WIDTH    = 14,
    parameter int                      DATA_WIDTH    = 16,
    parameter int                      LANE_WIDTH    = 8,
    parameter int                      BANK_BITS     = 2,
    parameter int                      INIT_ON_RESET = 1,
    parameter logic [DATA_WIDTH-1:0]   INIT_VALUE    = '0,
    localparam int                     LANES         = lanes_f(DATA_WIDTH, LANE_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [LANES-1:0]      req_lane_en,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic [BANK_BITS-1:0]  rsp_bank,
    output logic                  init_done,
    output ram_state_t            dbg_state
);

    localparam int         ROW_BITS    = row_bits_f(ADDR_WIDTH, BANK_BITS);
    localparam int         BANKS       = 1 << BANK_BITS;
    localparam ram_state_t RESET_STATE = (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;

    ram_state_t            state_q, state_d;
    logic [ROW_BITS-1:0]   row_q, row_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [BANK_BITS-1:0]  bank_q, bank_d;

    logic                  fill;
    logic                  accept, wr_acc, rd_acc;
    logic [BANK_BITS-1:0]  req_bank;
    logic [ROW_BITS-1:0]   req_row;
    logic [BANKS-1:0]      bank_sel;
    logic [LANES-1:0]      lane_we;
    logic [ROW_BITS-1:0]   bank_row;
    logic [DATA_WIDTH-1:0] bank_wdata;
    logic [DATA_WIDTH-1:0] bank_rdata [BANKS];

    assign fill      = (state_q == ST_INIT);
    assign req_bank  = req_addr[ADDR_WIDTH-1 -: BANK_BITS];
    assign req_row   = req_addr[ROW_BITS-1:0];
    assign req_ready = (state_q == ST_RUN) && (!rsp_valid_q || rsp_ready);
    assign accept    = req_valid && req_ready;
    assign wr_acc    = accept && req_we;
    assign rd_acc    = accept && !req_we;

    always_comb begin
        bank_sel           = '0;
        bank_sel[req_bank] = 1'b1;
    end

    // Fill walks every row once, writing all banks and lanes in parallel.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        if (fill) begin
            row_d = row_q + 1'b1;
            if (&row_q) begin
                state_d = ST_RUN;
            end
        end
    end

    // A pending response retires on rsp_ready unless a new read replaces it.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        bank_d      = bank_q;
        if (rd_acc) begin
            rsp_valid_d = 1'b1;
            bank_d      = req_bank;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RESET_STATE;
            row_q       <= '0;
            rsp_valid_q <= 1'b0;
            bank_q      <= '0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            rsp_valid_q <= rsp_valid_d;
            bank_q      <= bank_d;
        end
    end

    assign lane_we    = fill ? '1 : req_lane_en;
    assign bank_row   = fill ? row_q : req_row;
    assign bank_wdata = fill ? INIT_VALUE : req_wdata;

    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        ram_bank #(
            .ROW_BITS  (ROW_BITS),
            .DATA_WIDTH(DATA_WIDTH),
            .LANE_WIDTH(LANE_WIDTH),
            .LANES     (LANES)
        ) u_bank (
            .clk      (clk),
            .rst_n    (rst_n),
            .we_i     (fill || (wr_acc && bank_sel[b])),
            .lane_we_i(lane_we),
            .re_i     (rd_acc && bank_sel[b]),
            .row_i    (bank_row),
            .wdata_i  (bank_wdata),
            .rdata_o  (bank_rdata[b])
        );
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = bank_rdata[bank_q];
    assign rsp_bank  = bank_q;
    assign init_done = (state_q == ST_RUN);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_ram_banked_ctrl.sv
// Self-checking bench for ram_banked_ctrl with default parameters.
module tb_ram_banked_ctrl;
    import ram_banked_pkg::*;

    localparam int AW = 14;
    localparam int DW = 16;
    localparam int BB = 2;
    localparam int LN = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [LN-1:0] req_lane_en = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [DW-1:0] rsp_data;
    logic [BB-1:0] rsp_bank;
    logic          init_done;
    ram_state_t    dbg_state;

    int checks = 0;
    int errors = 0;
    logic [BB+DW-1:0] exp_q[$];

    ram_banked_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_lane_en(req_lane_en),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_bank   (rsp_bank),
        .init_done  (init_done),
        .dbg_state  (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // scoreboard: a response handshake happens at the coming edge
    always @(negedge clk) begin : monitor
        logic [BB+DW-1:0] e;
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got %0h expected no response", rsp_data);
            end else begin
                e = exp_q.pop_front();
                check("rsp_data", 32'(rsp_data), 32'(e[DW-1:0]));
                check("rsp_bank", 32'(rsp_bank), 32'(e[BB+DW-1:DW]));
            end
        end
    end

    // driver: called at posedge+1, returns at posedge+1 after acceptance
    task automatic do_req(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                          input logic [LN-1:0] le, input logic [DW-1:0] exp_d, output int stalls);
        int n = 0;
        req_valid   = 1'b1;
        req_we      = we;
        req_addr    = addr;
        req_wdata   = wd;
        req_lane_en = le;
        @(negedge clk);
        while (!req_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        stalls = n;
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL req_accept_timeout: got ready=0 expected ready=1 addr %0h", addr);
        end else if (!we) begin
            exp_q.push_back({addr[AW-1 -: BB], exp_d});
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // release reset and count edges until the fill completes
    task automatic wait_fill(input string tag);
        int cnt = 0;
        int rr_bad = 0;
        @(negedge clk);
        rst_n = 1'b1;
        while (!init_done && cnt < 5000) begin
            if (req_ready) rr_bad++;
            @(posedge clk);
            #1;
            cnt++;
        end
        check({tag, "_fill_cycles"}, 32'(cnt), 32'd4096);
        check({tag, "_ready_low_in_fill"}, 32'(rr_bad), 32'd0);
        check({tag, "_state_run"}, 32'(dbg_state), 32'(ST_RUN));
        check({tag, "_ready_after_fill"}, 32'(req_ready), 32'd1);
    endtask

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [LN-1:0] lane_en;
        logic [DW-1:0] exp_data;
    } vec_t;

    vec_t vecs[$];
    int   stalls;
    int   total_stalls;

    initial begin
        vecs = '{
            '{1'b0, 14'h3FFF, 16'h0000, 2'b00, 16'h0000},
            '{1'b1, 14'h0005, 16'h1A2B, 2'b11, 16'h0000},
            '{1'b1, 14'h0005, 16'hFFCC, 2'b01, 16'h0000},
            '{1'b0, 14'h0005, 16'h0000, 2'b00, 16'h1ACC},
            '{1'b1, 14'h0005, 16'hBEEF, 2'b11, 16'h0000},
            '{1'b1, 14'h1005, 16'h0000, 2'b11, 16'h0000},
            '{1'b1, 14'h2005, 16'h0000, 2'b11, 16'h0000},
            '{1'b1, 14'h3005, 16'h0000, 2'b11, 16'h0000},
            '{1'b0, 14'h0005, 16'h0000, 2'b00, 16'hBEEF},
            '{1'b0, 14'h1005, 16'h0000, 2'b00, 16'h0000},
            '{1'b0, 14'h2005, 16'h0000, 2'b00, 16'h0000},
            '{1'b0, 14'h3005, 16'h0000, 2'b00, 16'h0000},
            '{1'b1, 14'h2000, 16'h5555, 2'b11, 16'h0000},
            '{1'b0, 14'h2000, 16'h0000, 2'b00, 16'h5555},
            '{1'b1, 14'h1234, 16'hABCD, 2'b10, 16'h0000},
            '{1'b0, 14'h1234, 16'h0000, 2'b00, 16'hAB00},
            '{1'b1, 14'h1234, 16'hFFFF, 2'b00, 16'h0000},
            '{1'b0, 14'h1234, 16'h0000, 2'b00, 16'hAB00},
            '{1'b1, 14'h0FFF, 16'h1357, 2'b11, 16'h0000},
            '{1'b0, 14'h0FFF, 16'h0000, 2'b00, 16'h1357},
            '{1'b0, 14'h1000, 16'h0000, 2'b00, 16'h0000}
        };

        // reset state
        #12;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_rsp_bank", 32'(rsp_bank), 32'd0);
        check("rst_init_done", 32'(init_done), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(ST_INIT));

        wait_fill("boot");

        // table vectors back to back with rsp_ready held high
        total_stalls = 0;
        foreach (vecs[i]) begin
            do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].lane_en, vecs[i].exp_data, stalls);
            total_stalls += stalls;
        end
        for (int k = 0; k < 4; k++) begin
            do_req(1'b0, AW'(14'h0005 + 14'h1000 * k), '0, '0, (k == 0) ? 16'hBEEF : 16'h0000, stalls);
            total_stalls += stalls;
        end
        check("full_throughput_stalls", 32'(total_stalls), 32'd0);
        repeat (2) @(posedge clk);
        #1;

        // backpressure: response held for 3 cycles while a read waits
        rsp_ready = 1'b0;
        do_req(1'b0, 14'h0005, '0, '0, 16'hBEEF, stalls);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 14'h2000;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("bp_req_ready_low", 32'(req_ready), 32'd0);
            check("bp_rsp_valid_held", 32'(rsp_valid), 32'd1);
            check("bp_rsp_data_stable", 32'(rsp_data), 32'hBEEF);
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        do_req(1'b0, 14'h2000, '0, '0, 16'h5555, stalls);
        check("bp_release_stalls", 32'(stalls), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("bp_queue_drained", 32'(exp_q.size()), 32'd0);

        // reset with a response pending
        rsp_ready = 1'b0;
        do_req(1'b0, 14'h1234, '0, '0, 16'hAB00, stalls);
        check("pre_reset_rsp_valid", 32'(rsp_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst_req_ready", 32'(req_ready), 32'd0);
        check("midrst_init_done", 32'(init_done), 32'd0);
        check("midrst_rsp_data", 32'(rsp_data), 32'd0);
        exp_q.delete();
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        wait_fill("refill");
        do_req(1'b0, 14'h0005, '0, '0, 16'h0000, stalls);
        do_req(1'b0, 14'h2000, '0, '0, 16'h0000, stalls);
        do_req(1'b0, 14'h0FFF, '0, '0, 16'h0000, stalls);
        repeat (3) @(posedge clk);
        #1;
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
